// File: rtl/xctcmsg_pkg.sv
// Shared types and sizing for the xctcmsg mailbox / writeback datapath.
// Holds the writeback arbiter payload and the mailbox writeback buffer depth.
package xctcmsg_pkg;

  localparam int WB_BUFFER_DEPTH = 4;

  typedef struct packed {
    logic [7:0]  tag;
    logic [4:0]  rd_addr;
    logic [31:0] value;
  } writeback_arbiter_data_t;

  function automatic bit is_pow2_depth(int n);
    return (n >= 2) && ((n & (n - 1)) == 0);
  endfunction

endpackage

// File: rtl/mailbox_wb_buffer.sv
// Elastic FIFO between the mailbox receive path and the writeback arbiter.
// Optional XCTCMSG_WB_BUFFER_BYPASS_EN presents the input combinationally when empty.
module mailbox_wb_buffer
  import xctcmsg_pkg::*;
#(
  parameter int DEPTH = WB_BUFFER_DEPTH
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           flush,
  input  logic                           mailbox_wb_buffer_valid,
  output logic                           wb_buffer_mailbox_ready,
  input  writeback_arbiter_data_t        mailbox_wb_buffer_data,
  output logic                           wb_buffer_writeback_arbiter_valid,
  input  logic                           writeback_arbiter_wb_buffer_acknowledge,
  output writeback_arbiter_data_t        wb_buffer_writeback_arbiter_data,
  output logic [$clog2(DEPTH+1)-1:0]     wb_buffer_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  // Handshakes: a transfer happens on a cycle where valid && ready (ready for
  // the push side, acknowledge for the pop side); valid never waits on ready
  // and neither valid nor ready looks at the other side's acknowledge.

  writeback_arbiter_data_t mem [DEPTH];
  logic [PTR_W-1:0]        wr_ptr;
  logic [PTR_W-1:0]        rd_ptr;
  logic [CNT_W-1:0]        count;

  logic full;
  logic empty;
  logic push;
  logic pop;
  logic bypass_consume;

  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);

  assign wb_buffer_mailbox_ready = !full && !flush;
  assign wb_buffer_count         = count;

`ifdef XCTCMSG_WB_BUFFER_BYPASS_EN
  logic bypass_active;

  // Empty buffer forwards the mailbox result straight to the arbiter.
  assign bypass_active  = empty && mailbox_wb_buffer_valid && !flush;
  assign bypass_consume = bypass_active && writeback_arbiter_wb_buffer_acknowledge;

  assign wb_buffer_writeback_arbiter_valid = (!empty || mailbox_wb_buffer_valid) && !flush;
  assign wb_buffer_writeback_arbiter_data  = empty ? mailbox_wb_buffer_data : mem[rd_ptr];
`else
  assign bypass_consume = 1'b0;

  assign wb_buffer_writeback_arbiter_valid = !empty && !flush;
  assign wb_buffer_writeback_arbiter_data  = mem[rd_ptr];
`endif

  // A result consumed in bypass never occupies a slot.
  assign push = mailbox_wb_buffer_valid && wb_buffer_mailbox_ready && !bypass_consume;
  assign pop  = wb_buffer_writeback_arbiter_valid && writeback_arbiter_wb_buffer_acknowledge
                && !empty;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage is not reset; valid is derived from count, so stale data is never presented.
  always_ff @(posedge clk) begin
    if (push && !rst) begin
      mem[wr_ptr] <= mailbox_wb_buffer_data;
    end
  end

endmodule

// File: tb/tb_mailbox_wb_buffer.sv
// Directed testbench for mailbox_wb_buffer at DEPTH=4.
// Expectations follow the bypass build when XCTCMSG_WB_BUFFER_BYPASS_EN is defined.
module tb_mailbox_wb_buffer;
  import xctcmsg_pkg::*;

  localparam int DW = $bits(writeback_arbiter_data_t);
`ifdef XCTCMSG_WB_BUFFER_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic                    clk;
  logic                    rst;
  logic                    flush;
  logic                    mailbox_wb_buffer_valid;
  logic                    wb_buffer_mailbox_ready;
  writeback_arbiter_data_t mailbox_wb_buffer_data;
  logic                    wb_buffer_writeback_arbiter_valid;
  logic                    writeback_arbiter_wb_buffer_acknowledge;
  writeback_arbiter_data_t wb_buffer_writeback_arbiter_data;
  logic [2:0]              wb_buffer_count;

  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] dout_bits;
  int checks;
  int errors;

  assign dout_bits = wb_buffer_writeback_arbiter_data;

  mailbox_wb_buffer #(.DEPTH(4)) dut (
    .clk                                     (clk),
    .rst                                     (rst),
    .flush                                   (flush),
    .mailbox_wb_buffer_valid                 (mailbox_wb_buffer_valid),
    .wb_buffer_mailbox_ready                 (wb_buffer_mailbox_ready),
    .mailbox_wb_buffer_data                  (mailbox_wb_buffer_data),
    .wb_buffer_writeback_arbiter_valid       (wb_buffer_writeback_arbiter_valid),
    .writeback_arbiter_wb_buffer_acknowledge (writeback_arbiter_wb_buffer_acknowledge),
    .wb_buffer_writeback_arbiter_data        (wb_buffer_writeback_arbiter_data),
    .wb_buffer_count                         (wb_buffer_count)
  );

  // ---- clock / reset ----
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic writeback_arbiter_data_t mk(input logic [7:0] t);
    writeback_arbiter_data_t d;
    d.tag     = t;
    d.rd_addr = t[4:0];
    d.value   = {24'hDEAD00, t} ^ {t, 24'h0};
    return d;
  endfunction

  // ---- driver tasks ----
  task automatic drive(input logic v, input logic [7:0] t, input logic a, input logic f);
    mailbox_wb_buffer_valid                 = v;
    mailbox_wb_buffer_data                  = mk(t);
    writeback_arbiter_wb_buffer_acknowledge = a;
    flush                                   = f;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b0, 8'h00, 1'b0, 1'b1);
    checks++;
    if (wb_buffer_mailbox_ready !== 1'b0) begin
      errors++; $display("FAIL reset_flush_ready got=%0b exp=0", wb_buffer_mailbox_ready);
    end
    tick();
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    checks++;
    if (wb_buffer_mailbox_ready !== 1'b1) begin
      errors++; $display("FAIL reset_ready got=%0b exp=1", wb_buffer_mailbox_ready);
    end
    checks++;
    if (wb_buffer_writeback_arbiter_valid !== 1'b0) begin
      errors++; $display("FAIL reset_valid got=%0b exp=0", wb_buffer_writeback_arbiter_valid);
    end
    checks++;
    if (wb_buffer_count !== 3'd0) begin
      errors++; $display("FAIL reset_count got=%0d exp=0", wb_buffer_count);
    end
    tick();
    rst = 1'b0;
  endtask

  task automatic test_fill_drain();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 8'hA1 + 8'(i), 1'b0, 1'b0);
      checks++;
      if (wb_buffer_mailbox_ready !== 1'b1) begin
        errors++; $display("FAIL fill_ready[%0d] got=%0b exp=1", i, wb_buffer_mailbox_ready);
      end
      tick();
    end
    drive(1'b1, 8'hA5, 1'b0, 1'b0);
    checks++;
    if (wb_buffer_count !== 3'd4) begin
      errors++; $display("FAIL fill_count got=%0d exp=4", wb_buffer_count);
    end
    checks++;
    if (wb_buffer_mailbox_ready !== 1'b0) begin
      errors++; $display("FAIL full_ready got=%0b exp=0", wb_buffer_mailbox_ready);
    end
    tick();
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    checks++;
    if (wb_buffer_count !== 3'd4) begin
      errors++; $display("FAIL fifth_refused_count got=%0d exp=4", wb_buffer_count);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (wb_buffer_writeback_arbiter_valid !== 1'b1) begin
        errors++; $display("FAIL drain_valid[%0d] got=%0b exp=1", i, wb_buffer_writeback_arbiter_valid);
      end
      checks++;
      if (dout_bits !== DW'(mk(8'hA1 + 8'(i)))) begin
        errors++; $display("FAIL drain_data[%0d] got=%h exp=%h", i, dout_bits, mk(8'hA1 + 8'(i)));
      end
      tick();
    end
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    checks++;
    if (wb_buffer_count !== 3'd0) begin
      errors++; $display("FAIL drained_count got=%0d exp=0", wb_buffer_count);
    end
    checks++;
    if (wb_buffer_writeback_arbiter_valid !== 1'b0) begin
      errors++; $display("FAIL drained_valid got=%0b exp=0", wb_buffer_writeback_arbiter_valid);
    end
  endtask

  task automatic test_full_push_pop();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 8'hB1 + 8'(i), 1'b0, 1'b0);
      tick();
    end
    drive(1'b1, 8'hB5, 1'b1, 1'b0);
    checks++;
    if (wb_buffer_mailbox_ready !== 1'b0) begin
      errors++; $display("FAIL fullpp_ready got=%0b exp=0", wb_buffer_mailbox_ready);
    end
    checks++;
    if (dout_bits !== DW'(mk(8'hB1))) begin
      errors++; $display("FAIL fullpp_head got=%h exp=%h", dout_bits, mk(8'hB1));
    end
    tick();
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    checks++;
    if (wb_buffer_count !== 3'd3) begin
      errors++; $display("FAIL fullpp_count got=%0d exp=3", wb_buffer_count);
    end
    checks++;
    if (wb_buffer_mailbox_ready !== 1'b1) begin
      errors++; $display("FAIL fullpp_ready_next got=%0b exp=1", wb_buffer_mailbox_ready);
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 8'h00, 1'b1, 1'b0);
      checks++;
      if (dout_bits !== DW'(mk(8'hB2 + 8'(i)))) begin
        errors++; $display("FAIL fullpp_drain[%0d] got=%h exp=%h", i, dout_bits, mk(8'hB2 + 8'(i)));
      end
      tick();
    end
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    checks++;
    if (wb_buffer_count !== 3'd0) begin
      errors++; $display("FAIL fullpp_empty got=%0d exp=0", wb_buffer_count);
    end
  endtask

  // Shared stream model: the bench tracks its own occupancy and expected queue.
  task automatic test_stream(input string name, input int n_items, input logic [7:0] base,
                             input logic [15:0] ack_pat, input bit steady);
    int pushed = 0;
    int got = 0;
    int mcount = 0;
    int cyc = 0;
    logic in_v;
    logic a;
    logic ev;
    logic [DW-1:0] expd;
    exp_q.delete();
    while (got < n_items && cyc < 80) begin
      in_v = (pushed < n_items);
      a    = ack_pat[cyc % 16];
      drive(in_v, base + 8'(pushed), a, 1'b0);
      ev = (mcount > 0) || (BYP && in_v);
      checks++;
      if (wb_buffer_writeback_arbiter_valid !== ev) begin
        errors++; $display("FAIL %s_valid cyc%0d got=%0b exp=%0b", name, cyc, wb_buffer_writeback_arbiter_valid, ev);
      end
      checks++;
      if (int'(wb_buffer_count) !== mcount) begin
        errors++; $display("FAIL %s_count cyc%0d got=%0d exp=%0d", name, cyc, wb_buffer_count, mcount);
      end
      if (steady) begin
        checks++;
        if (wb_buffer_count > 3'd1) begin
          errors++; $display("FAIL %s_count_le1 cyc%0d got=%0d exp<=1", name, cyc, wb_buffer_count);
        end
      end
      if (ev && a) begin
        expd = (mcount > 0) ? exp_q[0] : DW'(mk(base + 8'(pushed)));
        checks++;
        if (dout_bits !== expd) begin
          errors++; $display("FAIL %s_data item%0d got=%h exp=%h", name, got, dout_bits, expd);
        end
        got++;
      end
      if (BYP && mcount == 0 && in_v && a) begin
        pushed++;
      end else begin
        if (mcount > 0 && a) begin
          void'(exp_q.pop_front());
          mcount--;
          if (in_v && mcount + 1 < 4) begin
            exp_q.push_back(DW'(mk(base + 8'(pushed)))); mcount++; pushed++;
          end
        end else if (in_v && mcount < 4) begin
          exp_q.push_back(DW'(mk(base + 8'(pushed)))); mcount++; pushed++;
        end
      end
      tick();
      cyc++;
    end
    checks++;
    if (got !== n_items) begin
      errors++; $display("FAIL %s_delivered got=%0d exp=%0d", name, got, n_items);
    end
    drive(1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic test_steady();
    test_stream("steady", 20, 8'h01, 16'hFFFF, 1'b1);
  endtask

  task automatic test_wrap();
    test_stream("wrap", 10, 8'h30, 16'b0110_1001_1100_0101, 1'b0);
  endtask

  task automatic test_flush();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 8'hC1 + 8'(i), 1'b0, 1'b0);
      tick();
    end
    drive(1'b1, 8'hC4, 1'b1, 1'b1);
    checks++;
    if (wb_buffer_writeback_arbiter_valid !== 1'b0) begin
      errors++; $display("FAIL flush_valid got=%0b exp=0", wb_buffer_writeback_arbiter_valid);
    end
    checks++;
    if (wb_buffer_mailbox_ready !== 1'b0) begin
      errors++; $display("FAIL flush_ready got=%0b exp=0", wb_buffer_mailbox_ready);
    end
    tick();
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    checks++;
    if (wb_buffer_count !== 3'd0) begin
      errors++; $display("FAIL post_flush_count got=%0d exp=0", wb_buffer_count);
    end
    checks++;
    if (wb_buffer_writeback_arbiter_valid !== 1'b0) begin
      errors++; $display("FAIL post_flush_valid got=%0b exp=0", wb_buffer_writeback_arbiter_valid);
    end
    drive(1'b1, 8'hC5, 1'b0, 1'b0);
    tick();
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    checks++;
    if (wb_buffer_count !== 3'd1) begin
      errors++; $display("FAIL flush_sole_count got=%0d exp=1", wb_buffer_count);
    end
    checks++;
    if (dout_bits !== DW'(mk(8'hC5))) begin
      errors++; $display("FAIL flush_sole_data got=%h exp=%h", dout_bits, mk(8'hC5));
    end
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    tick();
    drive(1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid_op();
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 8'hD1 + 8'(i), 1'b0, 1'b0);
      tick();
    end
    rst = 1'b1;
    drive(1'b1, 8'hD3, 1'b1, 1'b0);
    tick();
    rst = 1'b0;
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    checks++;
    if (wb_buffer_count !== 3'd0) begin
      errors++; $display("FAIL midrst_count got=%0d exp=0", wb_buffer_count);
    end
    checks++;
    if (wb_buffer_writeback_arbiter_valid !== 1'b0) begin
      errors++; $display("FAIL midrst_valid got=%0b exp=0", wb_buffer_writeback_arbiter_valid);
    end
  endtask

  task automatic test_bypass();
    drive(1'b1, 8'h55, 1'b1, 1'b0);
`ifdef XCTCMSG_WB_BUFFER_BYPASS_EN
    checks++;
    if (wb_buffer_writeback_arbiter_valid !== 1'b1) begin
      errors++; $display("FAIL bypass_valid got=%0b exp=1", wb_buffer_writeback_arbiter_valid);
    end
    checks++;
    if (dout_bits !== DW'(mk(8'h55))) begin
      errors++; $display("FAIL bypass_data got=%h exp=%h", dout_bits, mk(8'h55));
    end
    tick();
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    checks++;
    if (wb_buffer_count !== 3'd0) begin
      errors++; $display("FAIL bypass_count got=%0d exp=0", wb_buffer_count);
    end
`else
    checks++;
    if (wb_buffer_writeback_arbiter_valid !== 1'b0) begin
      errors++; $display("FAIL nobypass_valid0 got=%0b exp=0", wb_buffer_writeback_arbiter_valid);
    end
    tick();
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    checks++;
    if (wb_buffer_writeback_arbiter_valid !== 1'b1) begin
      errors++; $display("FAIL nobypass_valid1 got=%0b exp=1", wb_buffer_writeback_arbiter_valid);
    end
    checks++;
    if (dout_bits !== DW'(mk(8'h55))) begin
      errors++; $display("FAIL nobypass_data got=%h exp=%h", dout_bits, mk(8'h55));
    end
    tick();
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    checks++;
    if (wb_buffer_count !== 3'd0) begin
      errors++; $display("FAIL nobypass_count got=%0d exp=0", wb_buffer_count);
    end
`endif
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    flush = 1'b0;
    mailbox_wb_buffer_valid = 1'b0;
    mailbox_wb_buffer_data = '0;
    writeback_arbiter_wb_buffer_acknowledge = 1'b0;
    test_reset();
    test_fill_drain();
    test_full_push_pop();
    test_steady();
    test_wrap();
    test_flush();
    test_reset_mid_op();
    test_bypass();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
